// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the I-cache / D-cache memory arbiter.
//   state_e        : arbiter FSM states
//   gnt_e          : which cache owns the memory port
//   LINE_WORDS_DEF : default words per cache line
//   LINE_OFFSET_W  : default byte-offset width of a cache line
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int LINE_WORDS_DEF = 8;
    localparam int LINE_OFFSET_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D_RD,
        SERVE_D_WR,
        DONE
    } state_e;

    typedef enum logic {
        GNT_I,
        GNT_D
    } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the I-cache, D-cache and main-memory signals of the arbiter.
//   slave  : arbiter view (serves the caches, drives the memory strobes)
//   master : environment view (caches issuing requests plus the memory model)
// Parameters: ADDR_W byte-address width, DATA_W word width.
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // I-cache refill port
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rvalid;
    logic              ic_done;

    // D-cache refill / writeback port
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wready;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rvalid;
    logic              dc_done;

    // Main-memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rden;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Status
    logic              busy;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_rdata, mem_ack,
        output ic_rdata, ic_rvalid, ic_done,
        output dc_wready, dc_rdata, dc_rvalid, dc_done,
        output mem_addr, mem_wdata, mem_rden, mem_wen,
        output busy
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_rdata, mem_ack,
        input  ic_rdata, ic_rvalid, ic_done,
        input  dc_wready, dc_rdata, dc_rvalid, dc_done,
        input  mem_addr, mem_wdata, mem_rden, mem_wen,
        input  busy
    );
endinterface

// File: rtl/mem_burst_ctr.sv
// ----------------------------------------------------------------------------
// mem_burst_ctr
// Line base-address register and beat counter for one cache-line burst.
// Ports:
//   CLK, reset : clock, synchronous active-high reset
//   load       : capture addr_in (offset bits cleared) and restart at beat 0
//   advance    : memory accepted the current beat
//   addr_in    : requester line address
//   addr_out   : base + word-size * beat
//   last_beat  : current beat is the final word of the line
// ----------------------------------------------------------------------------
module mem_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int OFF_W      = LINE_OFFSET_W,
    parameter int WORD_SHIFT = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last_beat
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  beat_q;

    assign last_beat = (beat_q == LAST_BEAT);
    assign addr_out  = base_q + (ADDR_W'(beat_q) << WORD_SHIFT);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            base_q <= '0;
            beat_q <= '0;
        end else if (load) begin
            base_q <= addr_in & LINE_MASK;
            beat_q <= '0;
        end else if (advance) begin
            // Wrap explicitly so the counter is back at 0 for the next line
            // even when LINE_WORDS is not a power of two.
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one word-wide main-memory port between an I-cache (line refills)
// and a D-cache (line refills and dirty-line writebacks). A granted burst
// always runs LINE_WORDS beats, then a one-cycle DONE pulse, then IDLE.
// Ports:
//   CLK   : clock, rising edge
//   reset : synchronous active-high reset (abandons any burst in flight)
//   bus   : mem_arbiter_if.slave (cache request ports, memory port, busy)
// Build option:
//   MEM_ARB_RR_EN defined   -> simultaneous requests alternate (round-robin)
//   MEM_ARB_RR_EN undefined -> D-cache wins simultaneous requests
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic          CLK,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int WORD_SHIFT = $clog2(DATA_W / 8);
    localparam int OFF_W      = $clog2(LINE_WORDS) + WORD_SHIFT;

    state_e state_q, state_d;
    // Owner of the current (or most recent) burst. It doubles as the
    // last-grant memory for round-robin, so no separate register exists.
    gnt_e   gnt_q, gnt_d;
    gnt_e   gnt_pick;

    logic              load;
    logic              serve_i, serve_dr, serve_dw, serving, in_done;
    logic              last_beat;
    logic [ADDR_W-1:0] burst_addr;
    logic [ADDR_W-1:0] req_addr;

    // ------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE, where load qualifies it.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_pick = GNT_I;
        if (bus.ic_req && bus.dc_req) begin
`ifdef MEM_ARB_RR_EN
            gnt_pick = (gnt_q == GNT_I) ? GNT_D : GNT_I;
`else
            gnt_pick = GNT_D;
`endif
        end else if (bus.dc_req) begin
            gnt_pick = GNT_D;
        end
    end

    assign req_addr = (gnt_pick == GNT_I) ? bus.ic_addr : bus.dc_addr;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= GNT_I;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // branch can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    load  = 1'b1;
                    gnt_d = gnt_pick;
                    // dc_we is folded into the state, which registers it at grant.
                    if (gnt_pick == GNT_I) state_d = SERVE_I;
                    else if (bus.dc_we)    state_d = SERVE_D_WR;
                    else                   state_d = SERVE_D_RD;
                end
            end
            SERVE_I, SERVE_D_RD, SERVE_D_WR: begin
                if (bus.mem_ack && last_beat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter / address generation
    // ------------------------------------------------------------------
    mem_burst_ctr #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W),
        .WORD_SHIFT (WORD_SHIFT)
    ) u_burst_ctr (
        .CLK       (CLK),
        .reset     (reset),
        .load      (load),
        .advance   (serving && bus.mem_ack),
        .addr_in   (req_addr),
        .addr_out  (burst_addr),
        .last_beat (last_beat)
    );

    // ------------------------------------------------------------------
    // Outputs: decoded from the registered state; data and strobes are
    // gated so nothing leaks to a requester that does not own the port,
    // and mem_ack outside a SERVE state has no effect.
    // ------------------------------------------------------------------
    assign serve_i  = (state_q == SERVE_I);
    assign serve_dr = (state_q == SERVE_D_RD);
    assign serve_dw = (state_q == SERVE_D_WR);
    assign serving  = serve_i || serve_dr || serve_dw;
    assign in_done  = (state_q == DONE);

    assign bus.mem_rden  = serve_i || serve_dr;
    assign bus.mem_wen   = serve_dw;
    assign bus.mem_addr  = serving  ? burst_addr    : '0;
    assign bus.mem_wdata = serve_dw ? bus.dc_wdata  : '0;

    assign bus.ic_rdata  = serve_i  ? bus.mem_rdata : '0;
    assign bus.ic_rvalid = serve_i  && bus.mem_ack;
    assign bus.dc_rdata  = serve_dr ? bus.mem_rdata : '0;
    assign bus.dc_rvalid = serve_dr && bus.mem_ack;
    assign bus.dc_wready = serve_dw && bus.mem_ack;

    assign bus.ic_done   = in_done && (gnt_q == GNT_I);
    assign bus.dc_done   = in_done && (gnt_q == GNT_D);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a table of whole-line bursts, each row
// giving the requests, ack spacing and the hand-computed grant and line
// base, plus hand-written sequences for reset mid-burst and stray acks.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic reset;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LINE_WORDS (8)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        ic;
        logic        dc;
        logic        we;
        logic [31:0] ic_addr;
        logic [31:0] dc_addr;
        int          gap;       // mem_ack every gap-th cycle
        int          drop_beat; // drop requests at this beat, -1 = never
        logic        exp_i;     // expected owner: 1 = I-cache, 0 = D-cache
        logic [31:0] exp_base;  // expected line base address
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ic_req    = 1'b0;
        bus.dc_req    = 1'b0;
        bus.dc_we     = 1'b0;
        bus.ic_addr   = '0;
        bus.dc_addr   = '0;
        bus.dc_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    // Runs one complete burst described by v, with a simple memory model.
    task automatic run_burst(input vec_t v, input int idx);
        int          beat;
        int          cyc;
        int          pulses;
        bit          is_wr;
        bit          ack;
        logic [31:0] rpat;
        logic [31:0] wpat;
        is_wr = !v.exp_i && v.we;

        @(negedge CLK);
        bus.ic_req  = v.ic;
        bus.dc_req  = v.dc;
        bus.dc_we   = v.we;
        bus.ic_addr = v.ic_addr;
        bus.dc_addr = v.dc_addr;
        bus.mem_ack = 1'b0;
        #1;
        check($sformatf("%s idle busy", v.name), 32'(bus.busy), 32'd0);

        beat = 0; cyc = 0; pulses = 0;
        while (beat < 8 && cyc < 8 * v.gap + 16) begin
            @(negedge CLK);
            cyc++;
            if (beat == v.drop_beat) begin
                bus.ic_req = 1'b0;
                bus.dc_req = 1'b0;
            end
            ack  = (cyc % v.gap == 0);
            rpat = 32'hD000_0000 | 32'(idx << 8) | 32'(beat);
            wpat = 32'hC000_0000 | 32'(idx << 8) | 32'(beat);
            bus.mem_ack   = ack;
            bus.mem_rdata = rpat;
            bus.dc_wdata  = wpat;
            #1;
            check($sformatf("%s c%0d busy", v.name, cyc), 32'(bus.busy), 32'd1);
            check($sformatf("%s c%0d rden", v.name, cyc), 32'(bus.mem_rden), 32'(!is_wr));
            check($sformatf("%s c%0d wen", v.name, cyc), 32'(bus.mem_wen), 32'(is_wr));
            check($sformatf("%s c%0d addr", v.name, cyc), bus.mem_addr, v.exp_base + 32'(4 * beat));
            check($sformatf("%s c%0d ic_rvalid", v.name, cyc), 32'(bus.ic_rvalid), 32'(v.exp_i && ack));
            check($sformatf("%s c%0d dc_rvalid", v.name, cyc), 32'(bus.dc_rvalid), 32'(!v.exp_i && !is_wr && ack));
            check($sformatf("%s c%0d dc_wready", v.name, cyc), 32'(bus.dc_wready), 32'(is_wr && ack));
            check($sformatf("%s c%0d dones", v.name, cyc), 32'({bus.ic_done, bus.dc_done}), 32'd0);
            if (is_wr)
                check($sformatf("%s c%0d wdata", v.name, cyc), bus.mem_wdata, wpat);
            if (ack) begin
                if (v.exp_i)
                    check($sformatf("%s beat%0d ic_rdata", v.name, beat), bus.ic_rdata, rpat);
                else if (!is_wr)
                    check($sformatf("%s beat%0d dc_rdata", v.name, beat), bus.dc_rdata, rpat);
                pulses++;
                beat++;
            end
        end
        check($sformatf("%s serve cycles", v.name), 32'(cyc), 32'(8 * v.gap));
        check($sformatf("%s beat pulses", v.name), 32'(pulses), 32'd8);

        // DONE: one cycle, owner's done only, no strobes.
        @(negedge CLK);
        bus.mem_ack = 1'b0;
        bus.ic_req  = 1'b0;
        bus.dc_req  = 1'b0;
        #1;
        check($sformatf("%s done busy", v.name), 32'(bus.busy), 32'd1);
        check($sformatf("%s done ic_done", v.name), 32'(bus.ic_done), 32'(v.exp_i));
        check($sformatf("%s done dc_done", v.name), 32'(bus.dc_done), 32'(!v.exp_i));
        check($sformatf("%s done strobes", v.name), 32'({bus.mem_rden, bus.mem_wen}), 32'd0);

        @(negedge CLK);
        #1;
        check($sformatf("%s after busy", v.name), 32'(bus.busy), 32'd0);
        check($sformatf("%s after dones", v.name), 32'({bus.ic_done, bus.dc_done}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Table order matters: the first two rows rely on last-grant = I from reset.
        vecs[0] = '{"both_a",    1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3004, 1, -1,
                    1'b0, 32'h0000_3000};
        vecs[1] = '{"both_b",    1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3004, 1, -1,
                    RR, RR ? 32'h0000_2000 : 32'h0000_3000};
        vecs[2] = '{"ic_1234",   1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         1, -1,
                    1'b1, 32'h0000_1220};
        vecs[3] = '{"dc_wr_40",  1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0040, 3, -1,
                    1'b0, 32'h0000_0040};
        vecs[4] = '{"dc_rd_top", 1'b0, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFE7, 2, -1,
                    1'b0, 32'hFFFF_FFE0};
        vecs[5] = '{"ic_drop2",  1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0,         1, 2,
                    1'b1, 32'h8000_0000};

        // Reset with a stray ack and data on the memory bus: all outputs 0.
        idle_inputs();
        reset         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        bus.dc_wdata  = 32'hFFFF_FFFF;
        repeat (2) @(negedge CLK);
        #1;
        check("reset busy",    32'(bus.busy), 32'd0);
        check("reset strobes", 32'({bus.mem_rden, bus.mem_wen}), 32'd0);
        check("reset valids",  32'({bus.ic_rvalid, bus.dc_rvalid, bus.dc_wready}), 32'd0);
        check("reset dones",   32'({bus.ic_done, bus.dc_done}), 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        check("reset mem_wdata", bus.mem_wdata, 32'd0);
        check("reset ic_rdata", bus.ic_rdata, 32'd0);
        check("reset dc_rdata", bus.dc_rdata, 32'd0);
        @(negedge CLK);
        idle_inputs();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

        // Stray mem_ack while idle: nothing moves.
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h5A5A_0000 | 32'(c);
            #1;
            check($sformatf("spurious c%0d busy", c), 32'(bus.busy), 32'd0);
            check($sformatf("spurious c%0d valids", c),
                  32'({bus.ic_rvalid, bus.dc_rvalid, bus.dc_wready}), 32'd0);
            check($sformatf("spurious c%0d strobes", c), 32'({bus.mem_rden, bus.mem_wen}), 32'd0);
        end
        @(negedge CLK);
        bus.mem_ack = 1'b0;

        // Reset on beat 4 of an I-cache refill.
        @(negedge CLK);
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_1234;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            bus.mem_ack = 1'b1;
        end
        @(negedge CLK);
        #1;
        check("rst_mid beat4 addr", bus.mem_addr, 32'h0000_1230);
        reset = 1'b1;
        @(negedge CLK);
        #1;
        check("rst_mid busy",      32'(bus.busy), 32'd0);
        check("rst_mid rden",      32'(bus.mem_rden), 32'd0);
        check("rst_mid ic_done",   32'(bus.ic_done), 32'd0);
        check("rst_mid ic_rvalid", 32'(bus.ic_rvalid), 32'd0);
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            check($sformatf("rst_mid after c%0d ic_done", c), 32'(bus.ic_done), 32'd0);
            check($sformatf("rst_mid after c%0d busy", c), 32'(bus.busy), 32'd0);
        end
        v = '{"post_rst_dc", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1, -1,
              1'b0, 32'h0000_0100};
        run_burst(v, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
